// File: rtl/tdc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_ctrl
//  Purpose  : ADPLL phase-error sequencer. Opens a counting window on the
//             first of the reference / feedback edge pulses, closes it on the
//             other, averages 2^AVG_LOG2 signed samples and presents the
//             result over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tdc_ctrl #(
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             ref_edge_i,
    input  logic             fb_edge_i,
    output logic [WIDTH-1:0] err_o,
    output logic             err_valid_o,
    input  logic             err_ready_i,
    output logic             timeout_o,
    output logic             overrun_o
);

    localparam int CNTW = WIDTH - 1;
    localparam int ACCW = WIDTH + AVG_LOG2;
    // Sample counter keeps at least one bit so AVG_LOG2 = 0 still elaborates;
    // with a last-index of zero every sample then completes a result.
    localparam int SCW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [CNTW-1:0] C_CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] C_CNT_MAX = '1;   // 2^(WIDTH-1)-1 = saturation
    localparam logic [SCW-1:0]  C_SC_ONE  = SCW'(1);
    localparam logic [SCW-1:0]  C_SC_LAST = SCW'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEAS_REF = 2'd1;
    localparam logic [1:0] S_MEAS_FB  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic signed [ACCW-1:0]  acc_q;
    logic [SCW-1:0]          scnt_q;
    logic [WIDTH-1:0]        err_q;
    logic                    err_valid_q;
    logic                    timeout_q;
    logic                    overrun_q;

    logic [CNTW-1:0]         w_cnt_inc;
    logic [WIDTH-1:0]        w_mag;
    logic                    w_sat;
    logic                    w_sample_vld;
    logic signed [WIDTH-1:0] w_sample;
    logic                    w_timeout;
    logic signed [ACCW-1:0]  w_sum;
    logic [WIDTH-1:0]        w_result;
    logic                    w_load;
    logic                    w_xfer;

    // State register
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a window closes on the opposite edge or on saturation
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ref_edge_i && !fb_edge_i) begin
                        state_d = S_MEAS_REF;
                    end else if (fb_edge_i && !ref_edge_i) begin
                        state_d = S_MEAS_FB;
                    end
                end
                S_MEAS_REF: if (fb_edge_i || w_sat)  state_d = S_IDLE;
                S_MEAS_FB:  if (ref_edge_i || w_sat) state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Outputs of the FSM: window counter, completed sample and saturation flag
    always_comb begin
        w_cnt_inc    = cnt_q + C_CNT_ONE;
        w_mag        = {1'b0, w_cnt_inc};
        w_sat        = (w_cnt_inc == C_CNT_MAX);
        w_sample_vld = 1'b0;
        w_sample     = '0;
        w_timeout    = 1'b0;
        cnt_d        = cnt_q;
        if (enable_i) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    // Coincident edges are a zero-length window
                    if (ref_edge_i && fb_edge_i) begin
                        w_sample_vld = 1'b1;
                    end
                end
                S_MEAS_REF: begin
                    cnt_d = w_cnt_inc;
                    if (fb_edge_i || w_sat) begin
                        w_sample_vld = 1'b1;
                        w_sample     = w_mag;
                        w_timeout    = !fb_edge_i;
                    end
                end
                S_MEAS_FB: begin
                    cnt_d = w_cnt_inc;
                    if (ref_edge_i || w_sat) begin
                        w_sample_vld = 1'b1;
                        w_sample     = -w_mag;
                        w_timeout    = !ref_edge_i;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    // Average: the final sample is folded in combinationally before the shift
    always_comb begin
        w_sum    = acc_q + ACCW'(w_sample);
        w_result = WIDTH'(w_sum >>> AVG_LOG2);
        w_load   = w_sample_vld && (scnt_q == C_SC_LAST);
        w_xfer   = err_valid_q && err_ready_i;
    end

    // Window counter, accumulator and sample count
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            scnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= w_timeout;
            if (!enable_i) begin
                acc_q  <= '0;
                scnt_q <= '0;
            end else if (w_sample_vld) begin
                if (scnt_q == C_SC_LAST) begin
                    acc_q  <= '0;
                    scnt_q <= '0;
                end else begin
                    acc_q  <= w_sum;
                    scnt_q <= scnt_q + C_SC_ONE;
                end
            end
        end
    end

    // Result register and handshake; a result arriving into a full,
    // non-draining register is dropped and flagged
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            err_q       <= '0;
            err_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (w_load) begin
            if (!err_valid_q || w_xfer) begin
                err_q       <= w_result;
                err_valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (w_xfer) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_o       = err_q;
    assign err_valid_o = err_valid_q;
    assign timeout_o   = timeout_q;
    assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tdc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdc_ctrl
//  Purpose  : Self-checking bench for tdc_ctrl. A time-stamp based reference
//             model predicts every output each cycle; directed vectors with
//             literal expectations pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_ctrl;

    localparam int WIDTH    = 8;
    localparam int AVG_LOG2 = 2;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int MAXV     = (1 << (WIDTH - 1)) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             ref_e = 1'b0;
    logic             fb_e = 1'b0;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] err_o;
    logic             err_valid_o;
    logic             timeout_o;
    logic             overrun_o;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int to_seen  = 0;

    // Model state: leader (0 none, 1 ref, 2 fb), time stamp of leading edge
    int m_cyc = 0, m_lead = 0, m_t = 0, m_acc = 0, m_n = 0;
    int exp_err = 0;
    bit exp_v = 1'b0, exp_ovr = 1'b0, exp_to = 1'b0;

    tdc_ctrl #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) dut (
        .fpga_clk_i (clk),
        .reset_i    (rst),
        .enable_i   (en),
        .ref_edge_i (ref_e),
        .fb_edge_i  (fb_e),
        .err_o      (err_o),
        .err_valid_o(err_valid_o),
        .err_ready_i(ready),
        .timeout_o  (timeout_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Reference model: sample = signed elapsed time between leading and
    // closing edge, clipped at MAXV; results are floor averages of NAVG samples
    always @(posedge clk) begin : model
        int lead, t, acc, n, s, res, d, e_err;
        bit e_v, e_ovr, e_to, have, load, closing, xfer;
        lead = m_lead; t = m_t; acc = m_acc; n = m_n;
        e_err = exp_err; e_v = exp_v; e_ovr = exp_ovr;
        e_to = 1'b0; have = 1'b0; load = 1'b0; s = 0; res = 0;
        if (rst) begin
            lead = 0; acc = 0; n = 0; e_err = 0; e_v = 1'b0; e_ovr = 1'b0;
        end else begin
            if (!en) begin
                lead = 0; acc = 0; n = 0;
            end else if (lead == 0) begin
                if (ref_e && fb_e) begin
                    have = 1'b1; s = 0;
                end else if (ref_e) begin
                    lead = 1; t = m_cyc;
                end else if (fb_e) begin
                    lead = 2; t = m_cyc;
                end
            end else begin
                d = m_cyc - t;
                closing = (lead == 1) ? fb_e : ref_e;
                if (closing || d >= MAXV) begin
                    have = 1'b1;
                    if (d > MAXV) d = MAXV;
                    s = (lead == 1) ? d : -d;
                    e_to = !closing;
                    lead = 0;
                end
            end
            if (have) begin
                acc += s;
                n++;
                if (n == NAVG) begin
                    res = floor_div(acc, NAVG);
                    load = 1'b1;
                    acc = 0;
                    n = 0;
                end
            end
            xfer = e_v && ready;
            if (load) begin
                if (!e_v || xfer) begin
                    e_err = res; e_v = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (xfer) begin
                e_v = 1'b0;
            end
        end
        m_cyc   <= m_cyc + 1;
        m_lead  <= lead;
        m_t     <= t;
        m_acc   <= acc;
        m_n     <= n;
        exp_err <= e_err;
        exp_v   <= e_v;
        exp_ovr <= e_ovr;
        exp_to  <= e_to;
    end

    // Per-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("err_o", $signed(err_o), exp_err);
            check("err_valid_o", err_valid_o, exp_v);
            check("overrun_o", overrun_o, exp_ovr);
            check("timeout_o", timeout_o, exp_to);
        end
        if (timeout_o === 1'b1) to_seen++;
    end

    // d>0: ref leads by d; d<0: fb leads by -d; d==0: coincident
    task automatic window(input int d, input int gap);
        int ad;
        ad = (d < 0) ? -d : d;
        if (d == 0) begin
            ref_e = 1'b1; fb_e = 1'b1;
            @(negedge clk);
            ref_e = 1'b0; fb_e = 1'b0;
        end else begin
            if (d > 0) ref_e = 1'b1; else fb_e = 1'b1;
            @(negedge clk);
            ref_e = 1'b0; fb_e = 1'b0;
            repeat (ad - 1) @(negedge clk);
            if (d > 0) fb_e = 1'b1; else ref_e = 1'b1;
            @(negedge clk);
            ref_e = 1'b0; fb_e = 1'b0;
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin : stim
        int to_base;
        repeat (3) @(negedge clk);
        check("reset_err", $signed(err_o), 0);
        check("reset_valid", err_valid_o, 0);
        check("reset_timeout", timeout_o, 0);
        check("reset_overrun", overrun_o, 0);
        chk_en = 1'b1;
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) @(negedge clk);

        // 1: four +5 windows
        for (int i = 0; i < 3; i++) window(5, 2);
        window(5, 0);
        check("t1_valid", err_valid_o, 1);
        check("t1_err", $signed(err_o), 5);
        check("t1_model", exp_err, 5);
        accept();
        check("t1_drained", err_valid_o, 0);

        // 2: +4 -3 +2 -6 -> floor(-3/4) = -1, held while ready low
        window(4, 1); window(-3, 1); window(2, 1); window(-6, 0);
        check("t2_err", $signed(err_o), -1);
        check("t2_model", exp_err, -1);
        repeat (10) @(negedge clk);
        check("t2_err_held", $signed(err_o), -1);
        check("t2_overrun", overrun_o, 0);
        accept();

        // 3: coincident edges, then windows with repeated leading pulses
        for (int i = 0; i < 4; i++) window(0, 1);
        check("t3_zero", $signed(err_o), 0);
        accept();
        for (int i = 0; i < 4; i++) begin
            ref_e = 1'b1; @(negedge clk);
            ref_e = 1'b0; @(negedge clk);
            ref_e = 1'b1; @(negedge clk);
            ref_e = 1'b0; @(negedge clk);
            fb_e = 1'b1; ref_e = (i == 3);
            @(negedge clk);
            fb_e = 1'b0; ref_e = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("t3_extra_ref", $signed(err_o), 4);
        accept();

        // 4: saturating windows
        to_base = to_seen;
        for (int i = 0; i < 4; i++) begin
            ref_e = 1'b1; @(negedge clk);
            ref_e = 1'b0;
            repeat (130) @(negedge clk);
        end
        check("t4_timeouts", to_seen - to_base, 4);
        check("t4_err", $signed(err_o), 127);
        check("t4_model", exp_err, 127);
        accept();

        // 5: two results with no drain -> first retained, overrun set
        for (int i = 0; i < 4; i++) window(2, 1);
        for (int i = 0; i < 4; i++) window(6, 1);
        check("t5_err", $signed(err_o), 2);
        check("t5_overrun", overrun_o, 1);
        check("t5_valid", err_valid_o, 1);
        accept();
        check("t5_drained", err_valid_o, 0);

        // 6: abort mid-window, accumulated samples must be discarded
        window(20, 1); window(20, 1);
        ref_e = 1'b1; @(negedge clk);
        ref_e = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        fb_e = 1'b1; @(negedge clk);
        fb_e = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) window(3, 1);
        check("t6_err", $signed(err_o), 3);
        check("t6_valid", err_valid_o, 1);
        // reset mid-window with a result pending and overrun set
        ref_e = 1'b1; @(negedge clk);
        ref_e = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_err", $signed(err_o), 0);
        check("t6_rst_valid", err_valid_o, 0);
        check("t6_rst_overrun", overrun_o, 0);
        check("t6_rst_timeout", timeout_o, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
